// File: rtl/mul_div_unit_pkg.sv
// Shared op and state encodings for the multi-cycle CPU multiply/divide path.
// The control FSM decodes the same op values when it launches an MDU operation.
package mcpu_defs;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } mdu_state_e;

   function automatic logic mdu_is_signed(input mdu_op_e o);
      return (o == MDU_MULT) || (o == MDU_DIV);
   endfunction

   function automatic logic mdu_is_div(input mdu_op_e o);
      return (o == MDU_DIV) || (o == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: passes val_i through, or its negation when en_i is set.
module mdu_negate #(
   parameter int WIDTH = 32
) (
   input  logic             en_i,
   input  logic [WIDTH-1:0] val_i,
   output logic [WIDTH-1:0] val_o
);

   assign val_o = en_i ? (~val_i + 1'b1) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide. Works on operand magnitudes and
// applies the result signs in FIX; done is a one-cycle HI/LO load enable.
//
//   state | meaning
//   IDLE  | waiting for start; latches magnitudes, sign flags, zero-divisor flag
//   CALC  | WIDTH iterations of shift-add or shift-subtract
//   FIX   | applies sign fix-up, loads hi/lo, raises done for the next cycle
//   DONE  | done pulse; start ignored here
module mul_div_unit
   import mcpu_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div0
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_e         state_q;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   dvs_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [CW-1:0]      cnt_q;
   logic               is_div_q, dz_q, neg_res_q, neg_rem_q;
   logic               busy_q, done_q, div0_q;

   logic               in_signed, in_div, b_zero;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic [WIDTH:0]     sum, shifted, diff;

   assign in_signed = mdu_is_signed(mdu_op_e'(op));
   assign in_div    = mdu_is_div(mdu_op_e'(op));
   assign b_zero    = (b == '0);

   mdu_negate #(.WIDTH(WIDTH)) u_neg_a (
      .en_i(in_signed & a[WIDTH-1]), .val_i(a), .val_o(a_mag));
   mdu_negate #(.WIDTH(WIDTH)) u_neg_b (
      .en_i(in_signed & b[WIDTH-1]), .val_i(b), .val_o(b_mag));
   mdu_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
      .en_i(neg_res_q), .val_i(acc_q), .val_o(prod_fix));
   mdu_negate #(.WIDTH(WIDTH)) u_neg_quo (
      .en_i(neg_res_q), .val_i(acc_q[WIDTH-1:0]), .val_o(quo_fix));
   mdu_negate #(.WIDTH(WIDTH)) u_neg_rem (
      .en_i(neg_rem_q), .val_i(rem_q), .val_o(rem_fix));

   // acc low half holds the multiplier (mul) or the dividend shifting into the quotient (div)
   always_comb begin
      acc_d   = acc_q;
      rem_d   = rem_q;
      sum     = '0;
      shifted = '0;
      diff    = '0;
      if (is_div_q) begin
         shifted = {rem_q, acc_q[WIDTH-1]};
         diff    = shifted - {1'b0, dvs_q};
         rem_d   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
         acc_d   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
         sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
         acc_d = {sum, acc_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         dz_q      <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  is_div_q  <= in_div;
                  dz_q      <= in_div & b_zero;
                  neg_res_q <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem_q <= in_signed & a[WIDTH-1];
                  dvs_q     <= b_mag;
                  rem_q     <= '0;
                  cnt_q     <= '0;
                  div0_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  // a zero divisor skips iteration; the raw dividend is kept for hi
                  if (in_div & b_zero) begin
                     acc_q   <= {{WIDTH{1'b0}}, a};
                     state_q <= ST_FIX;
                  end else begin
                     acc_q   <= {{WIDTH{1'b0}}, a_mag};
                     state_q <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc_q <= acc_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH-1)) state_q <= ST_FIX;
            end
            ST_FIX: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               div0_q  <= dz_q;
               state_q <= ST_DONE;
               if (dz_q) begin
                  hi_q <= acc_q[WIDTH-1:0];
                  lo_q <= '1;
               end else if (is_div_q) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  {hi_q, lo_q} <= prod_fix;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign div0 = div0_q;

endmodule
